// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - load/store data-memory responder with programmable wait states
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              REQ_EN,
  input  logic              REQ_WE,
  input  logic [ADDR_W-1:0] REQ_ADDR,
  input  logic [31:0]       REQ_WDATA,
  input  logic [3:0]        REQ_BE,
  input  logic              LOAD_EN,
  input  logic [ADDR_W-1:0] LOAD_ADDR,
  input  logic [31:0]       LOAD_DATA,
  output logic              STALL,
  output logic              RSP_VALID,
  output logic              RSP_ERR,
  output logic [31:0]       RSP_RDATA
);

  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = DEPTH[ADDR_W:0];
  localparam logic [CNT_W-1:0] WAIT_L = WAIT_CYCLES[CNT_W-1:0];

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [3:0]         be_q;
  logic [31:0]        mem [DEPTH];

  logic accept, access, req_in_range, load_in_range, load_wr, store_wr;

  assign req_in_range  = ({1'b0, addr_q} < DEPTH_L);
  assign load_in_range = ({1'b0, LOAD_ADDR} < DEPTH_L);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    access  = 1'b0;
    load_wr = 1'b0;
    case (state_q)
      IDLE: begin
        if (LOAD_EN) begin
          load_wr = load_in_range;
        end else if (REQ_EN) begin
          accept  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign store_wr = access & we_q & req_in_range;
  assign STALL    = (state_q == BUSY) | ((state_q == IDLE) & LOAD_EN & REQ_EN);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      RSP_VALID <= 1'b0;
      RSP_ERR   <= 1'b0;
      RSP_RDATA <= '0;
    end else begin
      state_q   <= state_d;
      RSP_VALID <= access;
      RSP_ERR   <= access & ~req_in_range;
      if (accept) begin
        cnt_q <= WAIT_L;
      end else if (state_q == BUSY && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end
      if (access && !we_q) begin
        RSP_RDATA <= req_in_range ? mem[addr_q[IDX_W-1:0]] : 32'h0;
      end
    end
  end

  // Request fields are captured once so the requester may drop them after acceptance
  always_ff @(posedge CLK) begin
    if (accept) begin
      we_q    <= REQ_WE;
      addr_q  <= REQ_ADDR;
      wdata_q <= REQ_WDATA;
      be_q    <= REQ_BE;
    end
  end

  // Memory is never cleared; reset only suppresses writes so an aborted store has no effect
  always_ff @(posedge CLK) begin
    if (!RST) begin
      if (load_wr) begin
        mem[LOAD_ADDR[IDX_W-1:0]] <= LOAD_DATA;
      end else if (store_wr) begin
        for (int i = 0; i < 4; i++) begin
          if (be_q[i]) mem[addr_q[IDX_W-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench for dmem_responder
module tb_dmem_responder;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic        mon_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance a: two wait states
  logic        rst, req_en, req_we, load_en;
  logic [9:0]  req_addr, load_addr;
  logic [31:0] req_wdata, load_data;
  logic [3:0]  req_be;
  logic        stall, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  // instance z: zero wait states
  logic        rst_z, req_en_z, req_we_z, load_en_z;
  logic [9:0]  req_addr_z, load_addr_z;
  logic [31:0] req_wdata_z, load_data_z;
  logic [3:0]  req_be_z;
  logic        stall_z, rsp_valid_z, rsp_err_z;
  logic [31:0] rsp_rdata_z;

  dmem_responder #(.ADDR_W(10), .DEPTH(512), .WAIT_CYCLES(2)) u_dut (
    .CLK(clk), .RST(rst), .REQ_EN(req_en), .REQ_WE(req_we), .REQ_ADDR(req_addr),
    .REQ_WDATA(req_wdata), .REQ_BE(req_be), .LOAD_EN(load_en), .LOAD_ADDR(load_addr),
    .LOAD_DATA(load_data), .STALL(stall), .RSP_VALID(rsp_valid), .RSP_ERR(rsp_err),
    .RSP_RDATA(rsp_rdata)
  );

  dmem_responder #(.ADDR_W(10), .DEPTH(512), .WAIT_CYCLES(0)) u_dut_z (
    .CLK(clk), .RST(rst_z), .REQ_EN(req_en_z), .REQ_WE(req_we_z), .REQ_ADDR(req_addr_z),
    .REQ_WDATA(req_wdata_z), .REQ_BE(req_be_z), .LOAD_EN(load_en_z), .LOAD_ADDR(load_addr_z),
    .LOAD_DATA(load_data_z), .STALL(stall_z), .RSP_VALID(rsp_valid_z), .RSP_ERR(rsp_err_z),
    .RSP_RDATA(rsp_rdata_z)
  );

  typedef struct {
    int          cyc;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_z[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitors: pop an expectation whenever a response pulse appears
  logic prev_v_a = 1'b0;
  logic prev_v_z = 1'b0;

  always @(negedge clk) begin
    if (mon_on) begin
      if (rsp_valid === 1'b1) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_rsp", 32'(rsp_valid), 32'h0);
        end else begin
          exp_t e;
          e = q_a.pop_front();
          chk("a_rsp_cycle", 32'(cyc), 32'(e.cyc));
          chk("a_rsp_err", 32'(rsp_err), 32'(e.err));
          chk("a_rsp_rdata", rsp_rdata, e.data);
        end
        chk("a_valid_single", 32'(prev_v_a), 32'h0);
      end else begin
        chk("a_err_idle", 32'(rsp_err), 32'h0);
      end
      prev_v_a <= rsp_valid;
      if (rsp_valid_z === 1'b1) begin
        if (q_z.size() == 0) begin
          chk("z_unexpected_rsp", 32'(rsp_valid_z), 32'h0);
        end else begin
          exp_t e;
          e = q_z.pop_front();
          chk("z_rsp_cycle", 32'(cyc), 32'(e.cyc));
          chk("z_rsp_err", 32'(rsp_err_z), 32'(e.err));
          chk("z_rsp_rdata", rsp_rdata_z, e.data);
        end
        chk("z_valid_single", 32'(prev_v_z), 32'h0);
      end
      prev_v_z <= rsp_valid_z;
    end
  end

  task automatic drain_a(input string name);
    int n;
    n = 0;
    while (q_a.size() != 0 && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, 32'(q_a.size()), 32'h0);
  endtask

  task automatic drain_z(input string name);
    int n;
    n = 0;
    while (q_z.size() != 0 && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(name, 32'(q_z.size()), 32'h0);
  endtask

  task automatic preload_a(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic req_a(input string name, input logic we, input logic [9:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic eerr, input logic [31:0] edata);
    exp_t e;
    @(negedge clk);
    req_en = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
    #1 chk({name, "_stall_idle"}, 32'(stall), 32'h0);
    e.cyc = cyc + 4; e.err = eerr; e.data = edata;
    q_a.push_back(e);
    @(negedge clk);
    req_en = 1'b0; req_wdata = 32'hx; req_addr = 10'hx;
    for (int i = 0; i < 3; i++) begin
      #1 chk({name, "_stall_busy"}, 32'(stall), 32'h1);
      @(negedge clk);
    end
    #1 chk({name, "_stall_done"}, 32'(stall), 32'h0);
    drain_a({name, "_drain"});
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; req_en = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    rst_z = 1'b1; req_en_z = 1'b0; req_we_z = 1'b0; req_addr_z = '0; req_wdata_z = '0;
    req_be_z = '0; load_en_z = 1'b0; load_addr_z = '0; load_data_z = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst_z = 1'b0;
    #1;
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_valid", 32'(rsp_valid), 32'h0);
    chk("reset_err", 32'(rsp_err), 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_rdata_z", rsp_rdata_z, 32'h0);
    mon_on = 1'b1;

    // preload then read back
    preload_a(10'h038, 32'h0000_0002);
    req_a("load_038", 1'b0, 10'h038, 32'h0, 4'h0, 1'b0, 32'h0000_0002);

    // byte-enabled stores; stores leave RSP_RDATA at the last load value
    preload_a(10'h010, 32'hAABB_CCDD);
    req_a("store_be5", 1'b1, 10'h010, 32'h1122_3344, 4'b0101, 1'b0, 32'h0000_0002);
    req_a("load_010", 1'b0, 10'h010, 32'h0, 4'h0, 1'b0, 32'hAA22_CC44);
    req_a("store_be0", 1'b1, 10'h010, 32'hFFFF_FFFF, 4'b0000, 1'b0, 32'hAA22_CC44);
    req_a("load_010b", 1'b0, 10'h010, 32'h0, 4'h0, 1'b0, 32'hAA22_CC44);
    req_a("store_full", 1'b1, 10'h011, 32'h0F0E_0D0C, 4'b1111, 1'b0, 32'hAA22_CC44);
    req_a("load_011", 1'b0, 10'h011, 32'h0, 4'h0, 1'b0, 32'h0F0E_0D0C);

    // out of range
    req_a("load_oor", 1'b0, 10'h200, 32'h0, 4'h0, 1'b1, 32'h0);
    req_a("store_oor", 1'b1, 10'h3FF, 32'h1234_5678, 4'hF, 1'b1, 32'h0);

    // preload attempted while busy must be ignored
    @(negedge clk);
    req_en = 1'b1; req_we = 1'b0; req_addr = 10'h038;
    e.cyc = cyc + 4; e.err = 1'b0; e.data = 32'h0000_0002;
    q_a.push_back(e);
    @(negedge clk);
    req_en = 1'b0; load_en = 1'b1; load_addr = 10'h038; load_data = 32'hFFFF_FFFF;
    #1 chk("busy_load_stall", 32'(stall), 32'h1);
    @(negedge clk);
    load_en = 1'b0;
    drain_a("busy_load_drain");
    req_a("load_038b", 1'b0, 10'h038, 32'h0, 4'h0, 1'b0, 32'h0000_0002);

    // reset in the middle of a store aborts it
    preload_a(10'h005, 32'h1234_5678);
    @(negedge clk);
    req_en = 1'b1; req_we = 1'b1; req_addr = 10'h005; req_wdata = 32'hDEAD_BEEF; req_be = 4'hF;
    @(negedge clk);
    req_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1 chk("abort_stall", 32'(stall), 32'h0);
    chk("abort_rdata", rsp_rdata, 32'h0);
    repeat (6) @(negedge clk);
    req_a("load_005", 1'b0, 10'h005, 32'h0, 4'h0, 1'b0, 32'h1234_5678);

    // preload/request collision: preload wins, request waits
    @(negedge clk);
    load_en = 1'b1; load_addr = 10'h020; load_data = 32'h0BAD_F00D;
    req_en = 1'b1; req_we = 1'b0; req_addr = 10'h020;
    #1 chk("collide_stall", 32'(stall), 32'h1);
    @(negedge clk);
    load_en = 1'b0;
    #1 chk("collide_accept_stall", 32'(stall), 32'h0);
    e.cyc = cyc + 4; e.err = 1'b0; e.data = 32'h0BAD_F00D;
    q_a.push_back(e);
    @(negedge clk);
    req_en = 1'b0;
    #1 chk("collide_busy_stall", 32'(stall), 32'h1);
    drain_a("collide_drain");

    // zero-wait back-to-back with REQ_EN held high
    @(negedge clk);
    load_en_z = 1'b1; load_addr_z = 10'h001; load_data_z = 32'hCAFE_F00D;
    @(negedge clk);
    load_en_z = 1'b0;
    req_en_z = 1'b1; req_we_z = 1'b0; req_addr_z = 10'h001;
    #1 chk("z_stall_idle", 32'(stall_z), 32'h0);
    e.cyc = cyc + 2; e.err = 1'b0; e.data = 32'hCAFE_F00D;
    q_z.push_back(e);
    @(negedge clk);
    req_we_z = 1'b1; req_addr_z = 10'h002; req_wdata_z = 32'h0000_0055; req_be_z = 4'hF;
    #1 chk("z_stall_busy", 32'(stall_z), 32'h1);
    @(negedge clk);
    #1 chk("z_stall_rsp_cycle", 32'(stall_z), 32'h0);
    chk("z_valid_second_accept", 32'(rsp_valid_z), 32'h1);
    e.cyc = cyc + 2; e.err = 1'b0; e.data = 32'hCAFE_F00D;
    q_z.push_back(e);
    @(negedge clk);
    req_en_z = 1'b0;
    drain_z("z_b2b_drain");
    @(negedge clk);
    req_en_z = 1'b1; req_we_z = 1'b0; req_addr_z = 10'h002;
    e.cyc = cyc + 2; e.err = 1'b0; e.data = 32'h0000_0055;
    q_z.push_back(e);
    @(negedge clk);
    req_en_z = 1'b0;
    drain_z("z_load_drain");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
